euler_writeback: RTL and testbench
==================================

# euler_writeback

Result-side consumer for the Euler matrix-vector pipeline. Accepts one accumulated row result (`out_acc`, strobed by `data_ready`), reads the current state element x[i], forms x[i] + h·f[i] in fixed point with saturation, and writes it into the opposite bank of a ping-pong state memory. It counts rows and steps. When the last row of the last step has been written, it raises `FINAL_DONE` back to the pipeline's start FSM.

## Interface
Parameters:
- ADD_SIZE, 16, memory address width
- DATA_SIZE, 16, data width (signed two's complement)
- MAX_DIM, 6, row-index / step-count width
- FRAC_BITS, 8, fractional bits of the fixed-point format
- BANK_OFFSET, 64, address distance between state bank 0 and bank 1

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  level; a rising edge while IDLE begins a run
- shape_0  in  MAX_DIM  row count N (1..2^MAX_DIM-1)
- num_steps  in  MAX_DIM  Euler step count S (≥1)
- h_step  in  DATA_SIZE  step size h, Q(DATA_SIZE-FRAC_BITS).FRAC_BITS
- base_addr  in  ADD_SIZE  address of bank 0 element 0
- data_ready  in  1  one-cycle strobe: `out_acc` holds row result f[i]
- out_acc  in  DATA_SIZE  row result
- mem_rd_en  out  1  read strobe for the state memory
- mem_rd_addr  out  ADD_SIZE  read address
- mem_rd_data  in  DATA_SIZE  read data, valid exactly one cycle after mem_rd_en
- mem_wr_en  out  1  write strobe
- mem_wr_addr  out  ADD_SIZE  write address
- mem_wr_data  out  DATA_SIZE  write data
- bank_sel  out  1  bank the fetch stage reads this step
- FINAL_DONE  out  1  one-cycle pulse when the run completes
- overflow  out  1  sticky; set on saturation or a dropped result

## Operation
- FSM states: IDLE, WAIT_ROW, READ, UPDATE, WRITE, STEP_END.
- IDLE:
  - A rising edge of `start` clears row_idx, step_idx, bank_sel and overflow, then moves to WAIT_ROW.
- WAIT_ROW:
  - If `data_ready` is high, or the skid register is full, latch f (from the skid register first) and go to READ.
- READ:
  - Assert mem_rd_en for one cycle, with mem_rd_addr = base_addr + bank_sel·BANK_OFFSET + row_idx.
  - Go to UPDATE.
- UPDATE:
  - p = h_step × f, full 2·DATA_SIZE product, arithmetic shift right by FRAC_BITS, saturated to DATA_SIZE.
  - x_new = sat(mem_rd_data + p).
  - Register x_new. Either saturation sets overflow.
  - Go to WRITE.
- WRITE:
  - Assert mem_wr_en for one cycle, with mem_wr_addr = base_addr + (~bank_sel)·BANK_OFFSET + row_idx and mem_wr_data = x_new.
  - If row_idx = N-1, go to STEP_END. Otherwise row_idx++ and go to WAIT_ROW.
- STEP_END:
  - row_idx ← 0.
  - If step_idx = S-1, pulse FINAL_DONE and go to IDLE.
  - Otherwise step_idx++, toggle bank_sel and go to WAIT_ROW.
- Skid register (one entry): a `data_ready` arriving in READ, UPDATE, WRITE or STEP_END is stored in it. If the skid register is already full, the new result is dropped and overflow is set.
- Saturation clamps to +2^(DATA_SIZE-1)-1 and -2^(DATA_SIZE-1).

## Timing
- Reset values: all outputs 0, state IDLE, skid empty.
- With `data_ready` sampled at edge T:
  - mem_rd_en is high in cycle T..T+1.
  - mem_rd_data is sampled at edge T+2.
  - mem_wr_en is high in cycle T+2..T+3, so the write occurs 3 cycles after the strobe.
- Minimum result spacing without using the skid register: 4 cycles.
- FINAL_DONE is high for exactly one cycle, in the cycle after the last WRITE.
- The new bank_sel value is visible in the cycle after STEP_END.
- `start` held high after completion does not restart a run; a new rising edge is required.
- Reset mid-run aborts immediately. No further memory strobes are issued, and bank_sel returns to 0.
- A `data_ready` in IDLE is ignored.

## Structure
- Shared package holds:
  - the state enum (IDLE..STEP_END)
  - a saturating add function
  - a fixed-point multiply-shift-saturate function; the acc_stage reuses the same saturation rule.
- One sub-module, `fxp_mac_sat`: combinational h·f >>> FRAC_BITS plus x, with a saturation flag output.
- Start-edge detection and counters stay in the top level.

## Test plan
- N=3, S=1, h=0x0100 (1.0), x={0x0100,0x0200,0x0300}, f={0x0010,0x0020,0x0030}, strobes 6 cycles apart:
  - bank 1 ← {0x0110,0x0220,0x0330}
  - FINAL_DONE one cycle after the third write; overflow=0.
- N=2, S=2, h=0x0080 (0.5):
  - step 1 reads bank 0 and writes bank 1; bank_sel toggles to 1.
  - step 2 reads bank 1 and writes bank 0; FINAL_DONE once.
- Saturation, x=0x7F00, f=0x7FFF, h=0x0100:
  - mem_wr_data=0x7FFF, overflow=1 and stays 1 until the next start.
- Back-to-back results:
  - strobes at T and T+1: both written, at T+3 and T+7.
  - third strobe at T+2: dropped, overflow=1.
- Reset asserted in UPDATE: no mem_wr_en pulse; all outputs 0 asynchronously.
- `start` held high across FINAL_DONE: no second run; a low-then-high start begins a new run at step 0.

Source files
------------

// File: rtl/euler_writeback_pkg.sv
// Shared types and fixed-point helpers for the Euler write-back stage.
package euler_writeback_pkg;

  // Internal arithmetic width; wide enough for a full DATA_SIZE x DATA_SIZE product.
  localparam int WIDE = 64;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ROW,
    READ,
    UPDATE,
    WRITE,
    STEP_END
  } wb_state_t;

  // Clamp a wide signed value into a w-bit signed range; hit flags a clamp.
  function automatic logic signed [WIDE-1:0] sat_clamp(
    input  logic signed [WIDE-1:0] v,
    input  int                     w,
    output logic                   hit
  );
    logic signed [WIDE-1:0] hi;
    logic signed [WIDE-1:0] lo;
    logic signed [WIDE-1:0] res;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    hit = 1'b0;
    res = v;
    if (v > hi) begin
      res = hi;
      hit = 1'b1;
    end else if (v < lo) begin
      res = lo;
      hit = 1'b1;
    end
    return res;
  endfunction

  // Saturating add of two sign-extended w-bit operands.
  function automatic logic signed [WIDE-1:0] sat_add(
    input  logic signed [WIDE-1:0] a,
    input  logic signed [WIDE-1:0] b,
    input  int                     w,
    output logic                   hit
  );
    return sat_clamp(a + b, w, hit);
  endfunction

  // Fixed-point multiply, arithmetic shift by frac, then saturate to w bits.
  function automatic logic signed [WIDE-1:0] fxp_mul_shift_sat(
    input  logic signed [WIDE-1:0] a,
    input  logic signed [WIDE-1:0] b,
    input  int                     frac,
    input  int                     w,
    output logic                   hit
  );
    return sat_clamp((a * b) >>> frac, w, hit);
  endfunction

endpackage

// File: rtl/euler_writeback_fxp_mac_sat.sv
// Combinational y = sat(x + sat((h * f) >>> FRAC_BITS)) with a saturation flag.
module fxp_mac_sat
  import euler_writeback_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic [DATA_SIZE-1:0] h,
  input  logic [DATA_SIZE-1:0] f,
  input  logic [DATA_SIZE-1:0] x,
  output logic [DATA_SIZE-1:0] y,
  output logic                 sat
);

  logic signed [WIDE-1:0] h_w;
  logic signed [WIDE-1:0] f_w;
  logic signed [WIDE-1:0] x_w;
  logic signed [WIDE-1:0] p_w;
  logic                   p_hit;
  logic                   s_hit;

  // Sign-extend, scale h*f, then accumulate onto x with saturation at both steps.
  always_comb begin
    p_hit = 1'b0;
    s_hit = 1'b0;
    h_w   = WIDE'($signed(h));
    f_w   = WIDE'($signed(f));
    x_w   = WIDE'($signed(x));
    p_w   = fxp_mul_shift_sat(h_w, f_w, FRAC_BITS, DATA_SIZE, p_hit);
    y     = DATA_SIZE'(sat_add(x_w, p_w, DATA_SIZE, s_hit));
    sat   = p_hit | s_hit;
  end

endmodule

// File: rtl/euler_writeback.sv
// Euler write-back: x[i] <= sat(x[i] + h*f[i]) into the opposite ping-pong bank,
// counting rows and steps and flagging completion to the start FSM.
module euler_writeback
  import euler_writeback_pkg::*;
#(
  parameter int ADD_SIZE    = 16,
  parameter int DATA_SIZE   = 16,
  parameter int MAX_DIM     = 6,
  parameter int FRAC_BITS   = 8,
  parameter int BANK_OFFSET = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [MAX_DIM-1:0]   shape_0,
  input  logic [MAX_DIM-1:0]   num_steps,
  input  logic [DATA_SIZE-1:0] h_step,
  input  logic [ADD_SIZE-1:0]  base_addr,
  input  logic                 data_ready,
  input  logic [DATA_SIZE-1:0] out_acc,
  output logic                 mem_rd_en,
  output logic [ADD_SIZE-1:0]  mem_rd_addr,
  input  logic [DATA_SIZE-1:0] mem_rd_data,
  output logic                 mem_wr_en,
  output logic [ADD_SIZE-1:0]  mem_wr_addr,
  output logic [DATA_SIZE-1:0] mem_wr_data,
  output logic                 bank_sel,
  output logic                 FINAL_DONE,
  output logic                 overflow
);

  wb_state_t            state;
  logic                 start_q;
  logic [MAX_DIM-1:0]   row_idx;
  logic [MAX_DIM-1:0]   step_idx;
  logic [DATA_SIZE-1:0] f_reg;
  logic [DATA_SIZE-1:0] skid_data;
  logic                 skid_full;

  logic [DATA_SIZE-1:0] mac_y;
  logic                 mac_sat;
  logic [ADD_SIZE-1:0]  rd_addr;
  logic [ADD_SIZE-1:0]  wr_addr;
  logic                 last_row;
  logic                 last_step;
  logic                 busy;

  fxp_mac_sat #(
    .DATA_SIZE (DATA_SIZE),
    .FRAC_BITS (FRAC_BITS)
  ) u_mac (
    .h   (h_step),
    .f   (f_reg),
    .x   (mem_rd_data),
    .y   (mac_y),
    .sat (mac_sat)
  );

  // Bank addressing and loop-end decodes.
  always_comb begin
    rd_addr   = base_addr + (bank_sel ? ADD_SIZE'(BANK_OFFSET) : '0) + ADD_SIZE'(row_idx);
    wr_addr   = base_addr + (bank_sel ? '0 : ADD_SIZE'(BANK_OFFSET)) + ADD_SIZE'(row_idx);
    last_row  = (row_idx == shape_0 - MAX_DIM'(1));
    last_step = (step_idx == num_steps - MAX_DIM'(1));
    busy      = (state == READ) || (state == UPDATE) || (state == WRITE) || (state == STEP_END);
  end

  // Sequencer: all outputs registered; memory strobes and FINAL_DONE are one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      row_idx     <= '0;
      step_idx    <= '0;
      f_reg       <= '0;
      skid_data   <= '0;
      skid_full   <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      bank_sel    <= 1'b0;
      FINAL_DONE  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      start_q    <= start;
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      FINAL_DONE <= 1'b0;

      case (state)
        IDLE: begin
          if (start && !start_q) begin
            row_idx   <= '0;
            step_idx  <= '0;
            bank_sel  <= 1'b0;
            overflow  <= 1'b0;
            skid_full <= 1'b0;
            state     <= WAIT_ROW;
          end
        end
        WAIT_ROW: begin
          // The skid entry is older, so it is consumed first; a coincident
          // strobe refills the skid instead of being lost.
          if (skid_full) begin
            f_reg <= skid_data;
            if (data_ready) skid_data <= out_acc;
            else            skid_full <= 1'b0;
          end else if (data_ready) begin
            f_reg <= out_acc;
          end
          if (skid_full || data_ready) begin
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= rd_addr;
            state       <= READ;
          end
        end
        READ: begin
          state <= UPDATE;
        end
        UPDATE: begin
          mem_wr_en   <= 1'b1;
          mem_wr_addr <= wr_addr;
          mem_wr_data <= mac_y;
          if (mac_sat) overflow <= 1'b1;
          state <= WRITE;
        end
        WRITE: begin
          if (last_row) begin
            if (last_step) FINAL_DONE <= 1'b1;
            state <= STEP_END;
          end else begin
            row_idx <= row_idx + MAX_DIM'(1);
            state   <= WAIT_ROW;
          end
        end
        STEP_END: begin
          row_idx <= '0;
          if (last_step) begin
            state <= IDLE;
          end else begin
            step_idx <= step_idx + MAX_DIM'(1);
            bank_sel <= ~bank_sel;
            state    <= WAIT_ROW;
          end
        end
        default: state <= IDLE;
      endcase

      // Results arriving mid-row are parked; a second one while parked is lost.
      if (data_ready && busy) begin
        if (skid_full) begin
          overflow <= 1'b1;
        end else begin
          skid_data <= out_acc;
          skid_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_euler_writeback.sv
// Directed bench for euler_writeback with a behavioural state memory.
module tb_euler_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  shape_0 = 6'd1;
  logic [5:0]  num_steps = 6'd1;
  logic [15:0] h_step = 16'h0100;
  logic [15:0] base_addr = 16'h0010;
  logic        data_ready = 1'b0;
  logic [15:0] out_acc = '0;
  logic        mem_rd_en;
  logic [15:0] mem_rd_addr;
  logic [15:0] mem_rd_data = '0;
  logic        mem_wr_en;
  logic [15:0] mem_wr_addr;
  logic [15:0] mem_wr_data;
  logic        bank_sel;
  logic        FINAL_DONE;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [15:0] mem [0:255];

  int cyc = 0;
  int nwr = 0;
  int nrd = 0;
  int ndr = 0;
  int nfd = 0;
  int fd_cyc = 0;
  logic [15:0] wa_log [0:63];
  logic [15:0] wd_log [0:63];
  int          wc_log [0:63];
  logic [15:0] ra_log [0:63];
  int          dc_log [0:63];

  int w0, r0, d0, f0, w1, r1;

  euler_writeback #(
    .ADD_SIZE    (16),
    .DATA_SIZE   (16),
    .MAX_DIM     (6),
    .FRAC_BITS   (8),
    .BANK_OFFSET (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .shape_0     (shape_0),
    .num_steps   (num_steps),
    .h_step      (h_step),
    .base_addr   (base_addr),
    .data_ready  (data_ready),
    .out_acc     (out_acc),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .bank_sel    (bank_sel),
    .FINAL_DONE  (FINAL_DONE),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Memory model (read data one cycle after rd_en) plus event logs.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld_en) mem[ld_addr] <= ld_data;
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_rd_addr[7:0]];
      ra_log[nrd] <= mem_rd_addr;
      nrd <= nrd + 1;
    end
    if (mem_wr_en) begin
      mem[mem_wr_addr[7:0]] <= mem_wr_data;
      wa_log[nwr] <= mem_wr_addr;
      wd_log[nwr] <= mem_wr_data;
      wc_log[nwr] <= cyc;
      nwr <= nwr + 1;
    end
    if (data_ready) begin
      dc_log[ndr] <= cyc;
      ndr <= ndr + 1;
    end
    if (FINAL_DONE) begin
      nfd <= nfd + 1;
      fd_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send(input logic [15:0] f);
    @(negedge clk);
    data_ready = 1'b1; out_acc = f;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    idle(2);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(mem_wr_addr), 32'd0);
    chk("rst_final", 32'(FINAL_DONE), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_bank", 32'(bank_sel), 32'd0);
    rst = 1'b0;

    // N=3, S=1, h=1.0
    load(8'h10, 16'h0100); load(8'h11, 16'h0200); load(8'h12, 16'h0300);
    shape_0 = 6'd3; num_steps = 6'd1; h_step = 16'h0100;
    w0 = nwr; f0 = nfd;
    pulse_start();
    send(16'h0010); idle(4);
    send(16'h0020); idle(4);
    send(16'h0030); idle(6);
    chk("t1_nwr", 32'(nwr - w0), 32'd3);
    chk("t1_a0", 32'(wa_log[w0]), 32'h50);
    chk("t1_d0", 32'(wd_log[w0]), 32'h0110);
    chk("t1_a1", 32'(wa_log[w0+1]), 32'h51);
    chk("t1_d1", 32'(wd_log[w0+1]), 32'h0220);
    chk("t1_a2", 32'(wa_log[w0+2]), 32'h52);
    chk("t1_d2", 32'(wd_log[w0+2]), 32'h0330);
    chk("t1_nfd", 32'(nfd - f0), 32'd1);
    chk("t1_fd_time", 32'(fd_cyc - wc_log[w0+2]), 32'd1);
    chk("t1_ovf", 32'(overflow), 32'd0);

    // N=2, S=2, h=0.5: ping-pong across two steps
    load(8'h10, 16'h0100); load(8'h11, 16'h0200);
    shape_0 = 6'd2; num_steps = 6'd2; h_step = 16'h0080;
    w0 = nwr; r0 = nrd; f0 = nfd;
    pulse_start();
    send(16'h0040); idle(4);
    send(16'h0080); idle(5);
    chk("t2_bank_step2", 32'(bank_sel), 32'd1);
    send(16'h0020); idle(4);
    send(16'hFFC0); idle(6);
    chk("t2_rd0", 32'(ra_log[r0]), 32'h10);
    chk("t2_rd2", 32'(ra_log[r0+2]), 32'h50);
    chk("t2_a0", 32'(wa_log[w0]), 32'h50);
    chk("t2_d0", 32'(wd_log[w0]), 32'h0120);
    chk("t2_d1", 32'(wd_log[w0+1]), 32'h0240);
    chk("t2_a2", 32'(wa_log[w0+2]), 32'h10);
    chk("t2_d2", 32'(wd_log[w0+2]), 32'h0130);
    chk("t2_a3", 32'(wa_log[w0+3]), 32'h11);
    chk("t2_d3", 32'(wd_log[w0+3]), 32'h0220);
    chk("t2_nfd", 32'(nfd - f0), 32'd1);

    // Saturation
    load(8'h10, 16'h7F00);
    shape_0 = 6'd1; num_steps = 6'd1; h_step = 16'h0100;
    w0 = nwr; f0 = nfd;
    pulse_start();
    send(16'h7FFF); idle(6);
    chk("t3_d", 32'(wd_log[w0]), 32'h7FFF);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_nfd", 32'(nfd - f0), 32'd1);
    idle(4);
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);

    // Back-to-back strobes: skid holds one, third is dropped
    load(8'h10, 16'h0100); load(8'h11, 16'h0200);
    shape_0 = 6'd3; num_steps = 6'd1; h_step = 16'h0100;
    pulse_start();
    chk("t4_ovf_cleared", 32'(overflow), 32'd0);
    w0 = nwr; d0 = ndr;
    @(negedge clk) data_ready = 1'b1; out_acc = 16'h0001;
    @(negedge clk) out_acc = 16'h0002;
    @(negedge clk) out_acc = 16'h0003;
    @(negedge clk) data_ready = 1'b0;
    idle(8);
    chk("t4_nwr", 32'(nwr - w0), 32'd2);
    chk("t4_d0", 32'(wd_log[w0]), 32'h0101);
    chk("t4_d1", 32'(wd_log[w0+1]), 32'h0202);
    chk("t4_a1", 32'(wa_log[w0+1]), 32'h51);
    chk("t4_t0", 32'(wc_log[w0] - dc_log[d0]), 32'd3);
    chk("t4_t1", 32'(wc_log[w0+1] - dc_log[d0]), 32'd7);
    chk("t4_ovf", 32'(overflow), 32'd1);

    // Reset asserted while in UPDATE for row 2
    w0 = nwr;
    @(negedge clk) data_ready = 1'b1; out_acc = 16'h0003;
    @(negedge clk) data_ready = 1'b0;
    @(negedge clk) rst = 1'b1;
    #1;
    chk("t5_rd_en", 32'(mem_rd_en), 32'd0);
    chk("t5_wr_en", 32'(mem_wr_en), 32'd0);
    chk("t5_rd_addr", 32'(mem_rd_addr), 32'd0);
    chk("t5_wr_addr", 32'(mem_wr_addr), 32'd0);
    chk("t5_wr_data", 32'(mem_wr_data), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    idle(3);
    rst = 1'b0;
    idle(3);
    chk("t5_no_write", 32'(nwr - w0), 32'd0);

    // start held high across FINAL_DONE, then a fresh rising edge
    load(8'h10, 16'h0100);
    shape_0 = 6'd1; num_steps = 6'd1; h_step = 16'h0100;
    w0 = nwr; f0 = nfd;
    @(negedge clk) start = 1'b1;
    send(16'h0005); idle(6);
    chk("t6_d0", 32'(wd_log[w0]), 32'h0105);
    chk("t6_nfd", 32'(nfd - f0), 32'd1);
    idle(3);
    w1 = nwr; r1 = nrd;
    send(16'h0007); idle(6);
    chk("t6_no_restart_wr", 32'(nwr - w1), 32'd0);
    chk("t6_no_restart_rd", 32'(nrd - r1), 32'd0);
    @(negedge clk) start = 1'b0;
    pulse_start();
    send(16'h0009); idle(6);
    chk("t6_restart_a", 32'(wa_log[w1]), 32'h50);
    chk("t6_restart_d", 32'(wd_log[w1]), 32'h0109);
    chk("t6_nfd2", 32'(nfd - f0), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
